// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared types and constants for the memory-port bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    localparam int NREQ_MAX = 4;
    localparam int SEL_W    = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches upward from last+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [NREQ_MAX-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic                any,
    output logic [SEL_W-1:0]    idx,
    output logic [NREQ_MAX-1:0] onehot
);

    logic [SEL_W-1:0] w_cand;

    assign any = |req;

    always_comb begin
        idx    = '0;
        w_cand = '0;
        // Walk from the farthest offset to the nearest so the nearest one after last wins.
        for (int i = NREQ_MAX; i >= 1; i--) begin
            w_cand = last + SEL_W'(i);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

    always_comb begin
        onehot = '0;
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for the single core memory port; optional
//               ack timeout enabled by defining BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             mem_ack,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             mem_valid,
    output logic [NREQ-1:0]  done,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] w_last_nxt;
    logic             r_mem_valid;
    logic             w_valid_nxt;

    logic                w_pick_any;
    logic [SEL_W-1:0]    w_pick_idx;
    logic [NREQ_MAX-1:0] w_pick_onehot;
    logic                w_timeout;

    rr_pick u_rr_pick (
        .req    (req),
        .last   (r_last),
        .any    (w_pick_any),
        .idx    (w_pick_idx),
        .onehot (w_pick_onehot)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_to_cnt;

    // Held at zero in IDLE, so every transaction starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_to_cnt <= '0;
        end else if (!mem_ack) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == ST_GRANT) && !mem_ack && (r_to_cnt == c_TO_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^8'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_valid_nxt = r_mem_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick_onehot;
                    w_sel_nxt   = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_GRANT: begin
                // req is ignored here: a started transaction always completes or aborts.
                if (mem_ack || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_last      <= SEL_W'(NREQ_MAX - 1);
            r_mem_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_last      <= w_last_nxt;
            r_mem_valid <= w_valid_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign mem_valid = r_mem_valid;
    assign done      = r_gnt & {NREQ{mem_ack | w_timeout}};
    assign err       = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter (directed and random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int TIMEOUT = 16;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       mem_ack = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       mem_valid;
    logic [3:0] done;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: is a transaction in flight, who owns it, how long it has run.
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_last = 3;
    int m_gcyc = 0;

    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    logic       e_valid;
    logic [3:0] e_done;
    logic       e_err;

    bus_arbiter #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mem_ack   (mem_ack),
        .gnt       (gnt),
        .sel       (sel),
        .mem_valid (mem_valid),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic int rr_winner(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++) begin
            if (r[(lst + k) % 4]) return (lst + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_in(input logic [3:0] r, input logic a, input logic rst);
        bit hit;
        @(negedge clk);
        req = r;
        mem_ack = a;
        reset = rst;
        #1;
        hit     = TO_EN && m_busy && !a && (m_gcyc == TIMEOUT);
        e_gnt   = m_busy ? (4'b0001 << m_sel) : 4'b0000;
        e_sel   = 2'(m_sel);
        e_valid = m_busy;
        e_done  = (m_busy && (a || hit)) ? (4'b0001 << m_sel) : 4'b0000;
        e_err   = hit;
    endtask

    task automatic adv();
        int w;
        bit hit;
        @(posedge clk);
        hit = TO_EN && m_busy && !mem_ack && (m_gcyc == TIMEOUT);
        if (reset) begin
            m_busy = 1'b0; m_sel = 0; m_last = 3; m_gcyc = 0;
        end else if (!m_busy) begin
            w = rr_winner(req, m_last);
            if (w >= 0) begin
                m_busy = 1'b1; m_sel = w; m_last = w; m_gcyc = 1;
            end
        end else if (mem_ack || hit) begin
            m_busy = 1'b0;
        end else begin
            m_gcyc++;
        end
    endtask

    task automatic do_reset();
        set_in(4'b0000, 1'b0, 1'b1);
        adv();
    endtask

    task automatic test_reset();
        do_reset();
        set_in(4'b0000, 1'b0, 1'b0);
        n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
        n_checks++; if (sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", sel); else n_pass++;
        n_checks++; if (mem_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", mem_valid); else n_pass++;
        n_checks++; if (done !== 4'b0000 || err !== 1'b0) $display("FAIL reset_done_err: got %b/%b want 0000/0", done, err); else n_pass++;
        adv();
    endtask

    task automatic test_single();
        do_reset();
        set_in(4'b0100, 1'b0, 1'b0); adv();
        set_in(4'b0100, 1'b0, 1'b0);
        n_checks++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt); else n_pass++;
        n_checks++; if (sel !== 2'd2) $display("FAIL single_sel: got %0d want 2", sel); else n_pass++;
        n_checks++; if (mem_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", mem_valid); else n_pass++;
        adv();
        set_in(4'b0100, 1'b0, 1'b0); adv();
        set_in(4'b0100, 1'b1, 1'b0);
        n_checks++; if (done !== 4'b0100) $display("FAIL single_done: got %b want 0100", done); else n_pass++;
        adv();
        set_in(4'b0000, 1'b0, 1'b0);
        n_checks++; if (gnt !== 4'b0000 || mem_valid !== 1'b0) $display("FAIL single_release: got %b/%b want 0000/0", gnt, mem_valid); else n_pass++;
        n_checks++; if (sel !== 2'd2) $display("FAIL single_sel_hold: got %0d want 2", sel); else n_pass++;
        adv();
    endtask

    task automatic test_all_requesting();
        logic [3:0] want;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_in(4'b1111, 1'b1, 1'b0);
            want = (k % 2 == 1) ? (4'b0001 << ((k / 2) % 4)) : 4'b0000;
            n_checks++; if (gnt !== want) $display("FAIL all_gnt[%0d]: got %b want %b", k, gnt, want); else n_pass++;
            n_checks++; if (done !== want) $display("FAIL all_done[%0d]: got %b want %b", k, done, want); else n_pass++;
            adv();
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        set_in(4'b0100, 1'b0, 1'b0); adv();
        set_in(4'b0100, 1'b1, 1'b0); adv();
        set_in(4'b0011, 1'b0, 1'b0); adv();
        set_in(4'b0011, 1'b1, 1'b0);
        n_checks++; if (sel !== 2'd0) $display("FAIL wrap_sel0: got %0d want 0", sel); else n_pass++;
        adv();
        set_in(4'b0011, 1'b0, 1'b0); adv();
        set_in(4'b0011, 1'b1, 1'b0);
        n_checks++; if (sel !== 2'd1) $display("FAIL wrap_sel1: got %0d want 1", sel); else n_pass++;
        adv();
    endtask

    task automatic test_req_drop();
        do_reset();
        set_in(4'b0010, 1'b0, 1'b0); adv();
        for (int k = 0; k < 3; k++) begin
            set_in(4'b0000, 1'b0, 1'b0);
            n_checks++; if (gnt !== 4'b0010) $display("FAIL drop_gnt[%0d]: got %b want 0010", k, gnt); else n_pass++;
            adv();
        end
        set_in(4'b0000, 1'b1, 1'b0);
        n_checks++; if (done !== 4'b0010) $display("FAIL drop_done: got %b want 0010", done); else n_pass++;
        adv();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        set_in(4'b0001, 1'b0, 1'b0); adv();
        for (int c = 1; c <= TIMEOUT; c++) begin
            set_in(4'b0001, 1'b0, 1'b0);
            if (c < TIMEOUT) begin
                n_checks++; if (err !== 1'b0) $display("FAIL to_early_err[%0d]: got %b want 0", c, err); else n_pass++;
            end else begin
                n_checks++; if (err !== 1'b1 || done !== 4'b0001) $display("FAIL to_abort: got err=%b done=%b want 1/0001", err, done); else n_pass++;
            end
            adv();
        end
        set_in(4'b0000, 1'b0, 1'b0);
        n_checks++; if (gnt !== 4'b0000) $display("FAIL to_idle: got %b want 0000", gnt); else n_pass++;
        adv();
        set_in(4'b0001, 1'b0, 1'b0); adv();
        for (int c = 1; c <= TIMEOUT; c++) begin
            set_in(4'b0001, (c == TIMEOUT), 1'b0);
            if (c == TIMEOUT) begin
                n_checks++; if (err !== 1'b0 || done !== 4'b0001) $display("FAIL to_ack_wins: got err=%b done=%b want 0/0001", err, done); else n_pass++;
            end
            adv();
        end
    endtask
`endif

    task automatic test_reset_mid_grant();
        do_reset();
        set_in(4'b1000, 1'b0, 1'b0); adv();
        set_in(4'b1000, 1'b0, 1'b0);
        n_checks++; if (sel !== 2'd3) $display("FAIL midrst_sel: got %0d want 3", sel); else n_pass++;
        adv();
        set_in(4'b1000, 1'b0, 1'b1); adv();
        set_in(4'b1111, 1'b1, 1'b0);
        n_checks++; if (gnt !== 4'b0000 || mem_valid !== 1'b0 || done !== 4'b0000) $display("FAIL midrst_clear: got %b/%b/%b want 0000/0/0000", gnt, mem_valid, done); else n_pass++;
        adv();
        set_in(4'b1111, 1'b1, 1'b0);
        n_checks++; if (gnt !== 4'b0001 || sel !== 2'd0) $display("FAIL midrst_first: got %b/%0d want 0001/0", gnt, sel); else n_pass++;
        adv();
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic a, rst;
        int errs;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            r   = 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            set_in(r, a, rst);
            errs = 0;
            if (gnt !== e_gnt) errs++;
            if (sel !== e_sel) errs++;
            if (mem_valid !== e_valid) errs++;
            if (done !== e_done) errs++;
            if (err !== e_err) errs++;
            n_checks++;
            if (errs != 0)
                $display("FAIL random[%0d]: got gnt=%b sel=%0d v=%b done=%b err=%b want gnt=%b sel=%0d v=%b done=%b err=%b",
                         k, gnt, sel, mem_valid, done, err, e_gnt, e_sel, e_valid, e_done, e_err);
            else
                n_pass++;
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_wrap_skip();
        test_req_drop();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter sharing the single memory port of the RISC-V core among up to four requesters: instruction fetch, load/store unit, debug/loader and DMA. It grants one requester per transaction. Its registered 2-bit `sel` drives the select input of the 4:1 address/wdata/control multiplexer in front of the memory. It holds that grant until the memory acknowledges, then returns completion to the winner.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; fixed at 4, matching the 2-bit select of the 4:1 mux.
- `TIMEOUT`, 16: cycles to wait for `mem_ack` before abort; used only with `BUS_ARB_TIMEOUT_EN`; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  per-requester transaction request; must be held high until that requester's `done` bit pulses.
- `mem_ack`  in  1  memory completes the current transaction; sampled only in GRANT.
- `gnt`  out  4  one-hot grant, registered; all zero when idle.
- `sel`  out  2  index of the granted requester, registered; drives the 4:1 mux select.
- `mem_valid`  out  1  transaction valid to memory, registered; high exactly in GRANT.
- `done`  out  4  one-cycle completion pulse, combinational: `gnt & {4{mem_ack}}`, plus the abort pulse described under Configuration.
- `err`  out  1  one-cycle abort pulse; constant 0 when timeout is compiled out.

## Operation
States: IDLE, GRANT.

IDLE:
- `gnt` = 0 and `mem_valid` = 0.
- If `req` is nonzero, pick the winner by round-robin, searching from `last+1` upward mod 4.
- Next cycle: state = GRANT, `gnt` = one-hot(winner), `sel` = winner, `last` = winner.

GRANT:
- `gnt`, `sel` and `mem_valid` are held stable.
- `req` is ignored, including deassertion by the granted requester; the transaction always completes.
- On `mem_ack` = 1: `done[sel]` = 1 in the same cycle; next cycle state = IDLE with `gnt` = 0.

Fairness and throughput:
- There is a mandatory one-cycle IDLE bubble between transactions, so peak throughput is one transaction per 2 cycles.
- A requester that keeps `req` high loses to any other pending requester on the next arbitration.
- `mem_ack` while in IDLE is ignored; it produces no `done`.

Reset:
- State = IDLE, `gnt` = 0, `sel` = 0, `mem_valid` = 0, `err` = 0, `last` = 3, so requester 0 has first priority.
- Timeout counter = 0.
- Reset during GRANT abandons the transaction with no `done`; the memory side must also be reset.

## Timing
- Request to grant: `req` sampled high in IDLE in cycle N gives `gnt`/`mem_valid` in cycle N+1.
- Acknowledge: `mem_ack` in cycle M gives `done` in cycle M and `gnt` = 0 in cycle M+1.
- Minimum transaction: 2 cycles from grant, i.e. `mem_ack` is high in the first GRANT cycle.
- `sel` changes only on the IDLE→GRANT transition. It holds its value in IDLE, so the mux output is stable.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering GRANT and increments each GRANT cycle without `mem_ack`.
  - When it reaches `TIMEOUT` - 1 with no ack, `err` = 1 and `done[sel]` = 1 that cycle, and the next state is IDLE.
  - `mem_ack` in the same cycle takes precedence: normal completion, `err` = 0.
- Not defined: no counter; GRANT waits indefinitely; `err` is tied to 0.

## Structure
- Package `bus_arb_pkg`:
  - state encoding `ST_IDLE` = 1'b0, `ST_GRANT` = 1'b1;
  - `NREQ_MAX` = 4;
  - `SEL_W` = 2.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req[3:0]` and `last[1:0]`; outputs are `any`, `idx[1:0]` and `onehot[3:0]`. It is reused by the planned interrupt arbiter.

## Test plan
- Single requester: after reset, `req` = 4'b0100 → `gnt` = 4'b0100 and `sel` = 2 one cycle later; `mem_ack` after 3 cycles → `done` = 4'b0100 that cycle, `gnt` = 0 the next.
- All requesting: `req` = 4'b1111 held, `mem_ack` = 1 every GRANT cycle → grant order 0,1,2,3,0; `gnt` alternates grant/idle each cycle.
- Wrap and skip: `last` = 2, `req` = 4'b0011 → `sel` = 0; next arbitration with `req` = 4'b0011 → `sel` = 1.
- Request drop: requester 1 drops `req` during GRANT → `gnt` held at 4'b0010 until `mem_ack`; `done[1]` still pulses.
- Timeout (`BUS_ARB_TIMEOUT_EN`, `TIMEOUT` = 16): no `mem_ack` → `err` = 1 and `done` pulse in the 16th GRANT cycle, then IDLE. Ack in the 16th cycle → `err` = 0.
- Reset mid-GRANT: `reset` high for 1 cycle → `gnt` = 0, `mem_valid` = 0, `done` = 0 next cycle; the first arbitration after reset favours requester 0.
